// File: rtl/display_scan_ctrl_pkg.sv
// Shared encodings for the 7-segment scan controller.
package display_scan_ctrl_pkg;

  // Converter position selects; stepping is a decrement with wrap.
  localparam logic [1:0] SEL_TENS = 2'b11;
  localparam logic [1:0] SEL_ONES = 2'b10;
  localparam logic [1:0] SEL_DEC  = 2'b01;
  localparam logic [1:0] SEL_SYM  = 2'b00;

  // Segment decoder codes beyond 0-9.
  localparam logic [3:0] CODE_SYM  = 4'd10;
  localparam logic [3:0] CODE_DASH = 4'd11;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    SETTLE = 2'd1,
    SHOW   = 2'd2
  } scan_state_t;

  // The select encoding doubles as the digit enable bit index.
  function automatic logic [3:0] pos_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module scan_timer #(
  parameter int             W         = 4,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan sequencer for a 4-digit 7-segment display sharing one digit converter.
//
// state  | meaning
// BLANK  | all enables off, converter select already on the upcoming position
// SETTLE | one cycle for the converter output to settle; latched at its edge
// SHOW   | current position's enable lit (tens may stay dark for a leading 0)
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int BLANK_CYCLES = 16,
  parameter int ON_CYCLES    = 2048,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data_in,
  input  logic       decimal_in,
  input  logic [3:0] conv_digit,
  output logic       conv_reset_n,
  output logic [1:0] conv_select,
  output logic [7:0] conv_data,
  output logic       conv_decimal,
  output logic [3:0] digit_code,
  output logic [3:0] digit_en,
  output logic       frame_done,
  output logic       overflow
);

  localparam int MAX_CYC = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  // Timer holds remaining cycles minus one, so each state reloads N-1.
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LD    = CNT_W'(ON_CYCLES - 1);

  scan_state_t      state, state_n;
  logic [1:0]       pos, pos_n;
  logic             tmr_load, tmr_done, leave_sym;
  logic [CNT_W-1:0] tmr_val;

  logic [7:0] shadow_data, active_data;
  logic       shadow_dec, active_dec, pending;

  // Reset lands in tens BLANK, which is itself a state entry, so the timer
  // starts with the BLANK reload value.
  scan_timer #(
    .W         (CNT_W),
    .RESET_VAL (BLANK_LD)
  ) u_scan_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State and position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK;
      pos   <= SEL_TENS;
    end else begin
      state <= state_n;
      pos   <= pos_n;
    end
  end

  // Next-state logic; every transition reloads the timer for the new state.
  always_comb begin
    state_n   = state;
    pos_n     = pos;
    tmr_load  = 1'b0;
    tmr_val   = BLANK_LD;
    leave_sym = 1'b0;
    case (state)
      BLANK: begin
        if (tmr_done) begin
          state_n  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = '0;
        end
      end
      SETTLE: begin
        state_n  = SHOW;
        tmr_load = 1'b1;
        tmr_val  = ON_LD;
      end
      SHOW: begin
        if (tmr_done) begin
          state_n   = BLANK;
          pos_n     = pos - 2'd1;
          tmr_load  = 1'b1;
          tmr_val   = BLANK_LD;
          leave_sym = (pos == SEL_SYM);
        end
      end
      default: begin
        state_n  = BLANK;
        tmr_load = 1'b1;
        tmr_val  = BLANK_LD;
      end
    endcase
  end

  // Converter reset trails the block reset by one cycle; frame pulse is registered.
  always_ff @(posedge clk) begin
    conv_reset_n <= ~reset;
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= leave_sym;
    end
  end

  // Latch the converter digit at the end of SETTLE; dash out-of-range numbers.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_code <= 4'd0;
    end else if (state == SETTLE) begin
      if (overflow && (pos == SEL_TENS || pos == SEL_ONES)) begin
        digit_code <= CODE_DASH;
      end else begin
        digit_code <= conv_digit;
      end
    end
  end

  // Shadow/active buffering: a frame only ever sees one reading.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_data <= 8'd0;
      shadow_dec  <= 1'b0;
      active_data <= 8'd0;
      active_dec  <= 1'b0;
      pending     <= 1'b0;
    end else if (frame_done) begin
      pending <= 1'b0;
      if (load) begin
        shadow_data <= data_in;
        shadow_dec  <= decimal_in;
        active_data <= data_in;
        active_dec  <= decimal_in;
      end else if (pending) begin
        active_data <= shadow_data;
        active_dec  <= shadow_dec;
      end
    end else if (load) begin
      shadow_data <= data_in;
      shadow_dec  <= decimal_in;
      pending     <= 1'b1;
    end
  end

  // One-hot enable during SHOW, with optional leading-zero suppression on tens.
  always_comb begin
    digit_en = 4'b0000;
    if (state == SHOW &&
        !(LZ_BLANK && pos == SEL_TENS && digit_code == 4'd0)) begin
      digit_en = pos_onehot(pos);
    end
  end

  assign conv_select  = pos;
  assign conv_data    = active_data;
  assign conv_decimal = active_dec;
  assign overflow     = (active_data > 8'd99);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized scoreboard bench for display_scan_ctrl with a converter model.
module tb_display_scan_ctrl;

  localparam int B  = 2;
  localparam int O  = 4;
  localparam int DP = B + 1 + O;
  localparam int FP = 4 * DP;
  localparam bit LZ = 1'b1;

  logic       clk = 1'b0;
  logic       reset, load, decimal_in;
  logic [7:0] data_in;
  logic [3:0] conv_digit;
  logic       conv_reset_n, conv_decimal, frame_done, overflow;
  logic [1:0] conv_select;
  logic [7:0] conv_data;
  logic [3:0] digit_code, digit_en;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .BLANK_CYCLES (B),
    .ON_CYCLES    (O),
    .LZ_BLANK     (LZ)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .data_in      (data_in),
    .decimal_in   (decimal_in),
    .conv_digit   (conv_digit),
    .conv_reset_n (conv_reset_n),
    .conv_select  (conv_select),
    .conv_data    (conv_data),
    .conv_decimal (conv_decimal),
    .digit_code   (digit_code),
    .digit_en     (digit_en),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  // Behavioural binary-to-decimal converter sitting beside the block.
  always_comb begin
    conv_digit = 4'd0;
    if (conv_reset_n) begin
      case (conv_select)
        2'b11:   conv_digit = 4'((conv_data / 8'd10) % 8'd10);
        2'b10:   conv_digit = 4'(conv_data % 8'd10);
        2'b01:   conv_digit = conv_decimal ? 4'd5 : 4'd0;
        default: conv_digit = 4'd10;
      endcase
    end
  end

  // Expected frame: index 0 tens, 1 ones, 2 decimal, 3 symbol.
  typedef struct packed {
    logic [3:0][3:0] code;
    logic [3:0][3:0] en;
  } frame_t;

  frame_t sb[$];
  frame_t cur;
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  bit     running = 1'b0;
  logic [7:0] m_sh = 8'd0, m_act = 8'd0;
  logic       m_shd = 1'b0, m_actd = 1'b0, m_pend = 1'b0;

  function automatic frame_t expect_frame(input logic [7:0] d, input logic dec);
    frame_t f;
    if (d > 8'd99) begin
      f.code[0] = 4'd11;
      f.code[1] = 4'd11;
    end else begin
      f.code[0] = 4'(d / 8'd10);
      f.code[1] = 4'(d % 8'd10);
    end
    f.code[2] = dec ? 4'd5 : 4'd0;
    f.code[3] = 4'd10;
    f.en[0]   = (LZ && f.code[0] == 4'd0) ? 4'b0000 : 4'b1000;
    f.en[1]   = 4'b0100;
    f.en[2]   = 4'b0010;
    f.en[3]   = 4'b0001;
    return f;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame boundaries every FP cycles counted from reset.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      running = 1'b1;
      cyc     = 0;
      m_sh    = 8'd0;
      m_shd   = 1'b0;
      m_act   = 8'd0;
      m_actd  = 1'b0;
      m_pend  = 1'b0;
      sb.delete();
      sb.push_back(expect_frame(8'd0, 1'b0));
    end else if (running) begin
      if (cyc % FP == 0 && cyc > 0) begin
        if (load) begin
          m_act  = data_in;
          m_actd = decimal_in;
        end else if (m_pend) begin
          m_act  = m_sh;
          m_actd = m_shd;
        end
        m_pend = 1'b0;
        sb.push_back(expect_frame(m_act, m_actd));
      end else if (load) begin
        m_sh   = data_in;
        m_shd  = decimal_in;
        m_pend = 1'b1;
      end
      cyc++;
    end
  end

  // Monitor: per-cycle timing checks; pops a frame when tens settles.
  initial forever begin
    @(negedge clk);
    if (running) begin
      int k, p, ph;
      k  = cyc % FP;
      p  = k / DP;
      ph = k % DP;
      if (k == B) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty: got 0 frames want 1 (cycle %0d)", cyc);
        end else begin
          cur = sb.pop_front();
        end
      end
      chk("frame_done",   int'(frame_done),   int'(k == 0 && cyc > 0));
      chk("conv_select",  int'(conv_select),  3 - p);
      chk("conv_reset_n", int'(conv_reset_n), int'(cyc != 0));
      chk("conv_data",    int'(conv_data),    int'(m_act));
      chk("conv_decimal", int'(conv_decimal), int'(m_actd));
      chk("overflow",     int'(overflow),     int'(m_act > 8'd99));
      if (ph < B + 1) begin
        chk("digit_en_gap", int'(digit_en), 0);
      end else begin
        chk("digit_en",   int'(digit_en),   int'(cur.en[p]));
        chk("digit_code", int'(digit_code), int'(cur.code[p]));
      end
    end
  end

  task automatic wait_k(input int k);
    for (int i = 0; i < 2 * FP; i++) begin
      @(negedge clk);
      if (cyc % FP == k) return;
    end
    total++;
    bad++;
    $display("FAIL wait_phase: got timeout want phase %0d", k);
  endtask

  task automatic do_load(input logic [7:0] d, input logic dc);
    load       = 1'b1;
    data_in    = d;
    decimal_in = dc;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    data_in    = 8'd0;
    decimal_in = 1'b0;
    @(negedge clk);
    load       = 1'b1;
    data_in    = 8'd99;
    decimal_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    chk("reset_digit_code", int'(digit_code), 0);
    chk("reset_digit_en",   int'(digit_en),   0);

    wait_k(5);  do_load(8'd37, 1'b1);
    wait_k(5);  do_load(8'd5, 1'b0);
    wait_k(5);  do_load(8'd150, 1'b0);
    wait_k(4);  do_load(8'd42, 1'b0);
    wait_k(20); do_load(8'd43, 1'b0);
    wait_k(10); do_load(8'd61, 1'b1);
    wait_k(0);  do_load(8'd88, 1'b0);
    wait_k(FP - 1);
    wait_k(FP - 1);

    for (int i = 0; i < 8; i++) begin
      wait_k(int'($urandom_range(FP - 1, 0)));
      do_load(8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
    end
    wait_k(FP - 1);

    do_load(8'd97, 1'b1);
    wait_k(FP - 1);
    wait_k(9);
    do_load(8'd77, 1'b1);
    wait_k(11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_digit_en", int'(digit_en), 0);
    chk("midreset_conv_rst", int'(conv_reset_n), 0);
    repeat (2 * FP + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
